asg_stream_decryptor: RTL

Receive-side consumer of the alternating step generator (ASG) keystream. It regenerates the identical ASG keystream from a shared seed triple and XORs it with incoming ciphertext nibbles to recover plaintext. It sits between a ciphertext source and a plaintext sink, with valid/ready handshakes on both sides, and advances the keystream exactly once per accepted nibble.

---
 rtl/asg_pkg.sv | 40 ++++
 rtl/asg_core.sv | 43 ++++
 rtl/asg_stream_decryptor.sv | 80 ++++++++
 3 files changed

// File: rtl/asg_pkg.sv
// Shared definitions for the alternating step generator: nibble width, FSM
// states and the single-step function used by both generator and decryptor.
package asg_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    UNSEEDED = 2'd0,
    RUN      = 2'd1,
    ERR      = 2'd2
  } asg_fsm_e;

  typedef struct packed {
    logic [NIB_W-1:0] ctrl;
    logic [NIB_W-1:0] l0;
    logic [NIB_W-1:0] l1;
    logic [NIB_W-1:0] ks;
  } asg_state_t;

  // Control LFSR always clocks; its feedback bit picks which data LFSR steps.
  // The keystream nibble is formed from the post-step data LFSR values.
  function automatic asg_state_t asg_step(input logic [NIB_W-1:0] ctrl,
                                          input logic [NIB_W-1:0] l0,
                                          input logic [NIB_W-1:0] l1);
    asg_state_t r;
    logic       fb;
    fb     = ctrl[0] ^ ctrl[1];
    r.ctrl = {fb, ctrl[NIB_W-1:1]};
    r.l0   = l0;
    r.l1   = l1;
    if (fb) begin
      r.l1 = {l1[1] ^ l1[0], l1[NIB_W-1:1]};
    end else begin
      r.l0 = {l0[1] ^ l0[0], l0[NIB_W-1:1]};
    end
    r.ks = r.l0 ^ r.l1;
    return r;
  endfunction

endpackage

// File: rtl/asg_core.sv
// Keystream register bank: control LFSR plus the two data LFSRs, with seed
// load and single-step enables. ks is the nibble produced by the pending step.
module asg_core
  import asg_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [NIB_W-1:0] seed_ctrl,
  input  logic [NIB_W-1:0] seed_0,
  input  logic [NIB_W-1:0] seed_1,
  output logic [NIB_W-1:0] ks
);

  logic [NIB_W-1:0] ctrl;
  logic [NIB_W-1:0] l0;
  logic [NIB_W-1:0] l1;
  asg_state_t       nxt;

  always_comb begin
    nxt = asg_step(ctrl, l0, l1);
    ks  = nxt.ks;
  end

  // Load wins over step so a reseed never mixes with a keystream advance.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      l0   <= '0;
      l1   <= '0;
    end else if (load) begin
      ctrl <= seed_ctrl;
      l0   <= seed_0;
      l1   <= seed_1;
    end else if (step) begin
      ctrl <= nxt.ctrl;
      l0   <= nxt.l0;
      l1   <= nxt.l1;
    end
  end

endmodule

// File: rtl/asg_stream_decryptor.sv
// ASG stream decryptor: XORs each accepted ciphertext nibble with the next
// keystream nibble into a single-entry output register with valid/ready.
module asg_stream_decryptor
  import asg_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [3:0]       seed_ctrl,
  input  logic [3:0]       seed_0,
  input  logic [3:0]       seed_1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             seed_err,
  output logic [CNT_W-1:0] nib_count
);

  asg_fsm_e   state_q;
  asg_fsm_e   state_d;
  logic       seeds_ok;
  logic       accept;
  logic [3:0] ks;

  assign seeds_ok = (seed_ctrl != '0) && (seed_0 != '0) && (seed_1 != '0);
  assign in_ready = (state_q == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !seed_load;
  assign seed_err = (state_q == ERR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= UNSEEDED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (seed_load) begin
      state_d = seeds_ok ? RUN : ERR;
    end
  end

  asg_core u_core (
    .clock     (clock),
    .reset     (reset),
    .load      (seed_load),
    .step      (accept),
    .seed_ctrl (seed_ctrl),
    .seed_0    (seed_0),
    .seed_1    (seed_1),
    .ks        (ks)
  );

  // A reload discards any pending plaintext; out_data is left as-is since
  // it is only meaningful while out_valid is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      nib_count <= '0;
    end else if (seed_load) begin
      out_valid <= 1'b0;
      nib_count <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ ks;
      nib_count <= nib_count + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
